// File: rtl/wb_regfile.sv
// wb_regfile: RISC-V writeback select, 32x32 register file with x0 hardwired, and commit counter.
// Define WB_BYPASS_EN to forward the same-cycle writeback value onto the read ports.
module wb_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [XLEN-1:0]         readdata_in,
    input  logic [XLEN-1:0]         alu_result_in,
    input  logic [$clog2(NREG)-1:0] rd_in,
    input  logic                    memtoreg_in,
    input  logic                    regwrite_in,
    input  logic [$clog2(NREG)-1:0] rs1_addr,
    input  logic [$clog2(NREG)-1:0] rs2_addr,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    output logic [XLEN-1:0]         wb_data_out,
    output logic [$clog2(NREG)-1:0] wb_rd_out,
    output logic                    wb_en_out,
    output logic [31:0]             wb_count
);
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    logic [XLEN-1:0] regs [NREG];
    assign wb_data_out = memtoreg_in ? readdata_in : alu_result_in;
    assign wb_rd_out   = rd_in;
    assign wb_en_out   = regwrite_in && (rd_in != '0);
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            wb_count <= '0;
        end else if (wb_en_out) begin
            regs[rd_in] <= wb_data_out;
            wb_count    <= wb_count + 32'd1;
        end
    end
    // x0 reads as zero even if the bypass would match
    assign rs1_data = (rs1_addr == '0) ? '0 :
                      (BYPASS && wb_en_out && rs1_addr == rd_in) ? wb_data_out : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 :
                      (BYPASS && wb_en_out && rs2_addr == rd_in) ? wb_data_out : regs[rs2_addr];
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile; expectations queued at drive time, popped at negedge.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] readdata_in, alu_result_in;
    logic [4:0]  rd_in, rs1_addr, rs2_addr;
    logic        memtoreg_in, regwrite_in;
    logic [31:0] rs1_data, rs2_data, wb_data_out, wb_count;
    logic [4:0]  wb_rd_out;
    logic        wb_en_out;

    wb_regfile dut (
        .clk(clk), .reset(reset), .readdata_in(readdata_in), .alu_result_in(alu_result_in),
        .rd_in(rd_in), .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_data_out(wb_data_out), .wb_rd_out(wb_rd_out), .wb_en_out(wb_en_out), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] mem [32];
    logic [31:0] cnt;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a, input logic en, input logic [4:0] rd,
                                             input logic [31:0] wb);
        if (a == 5'd0) return 32'd0;
        if (BYP && en && a == rd) return wb;
        return mem[a];
    endfunction

    // one clock cycle: drive at posedge+1, check at negedge, update model at posedge
    task automatic cyc(input logic rst, input logic we, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] rdata, input logic [31:0] alu,
                       input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] wb;
        logic        en;
        exp_t        e;
        reset = rst; regwrite_in = we; memtoreg_in = m2r; rd_in = rd;
        readdata_in = rdata; alu_result_in = alu; rs1_addr = a1; rs2_addr = a2;
        wb = m2r ? rdata : alu;
        en = we && rd != 5'd0;
        sb.push_back('{"rs1_data", model_rd(a1, en, rd, wb)});
        sb.push_back('{"rs2_data", model_rd(a2, en, rd, wb)});
        sb.push_back('{"wb_count", cnt});
        sb.push_back('{"wb_en_out", {31'd0, en}});
        sb.push_back('{"wb_data_out", wb});
        sb.push_back('{"wb_rd_out", {27'd0, rd}});
        @(negedge clk);
        e = sb.pop_front(); check(e.tag, rs1_data, e.val);
        e = sb.pop_front(); check(e.tag, rs2_data, e.val);
        e = sb.pop_front(); check(e.tag, wb_count, e.val);
        e = sb.pop_front(); check(e.tag, {31'd0, wb_en_out}, e.val);
        e = sb.pop_front(); check(e.tag, wb_data_out, e.val);
        e = sb.pop_front(); check(e.tag, {27'd0, wb_rd_out}, e.val);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'd0;
            cnt = 32'd0;
        end else if (en) begin
            mem[rd] = wb;
            cnt = cnt + 32'd1;
        end
        #1;
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        regwrite_in = 1'b0; reset = 1'b0; rs1_addr = a; rs2_addr = a;
        #1;
        check({tag, "_p1"}, rs1_data, exp);
        check({tag, "_p2"}, rs2_data, exp);
    endtask

    initial begin
        reset = 1'b1; regwrite_in = 1'b0; memtoreg_in = 1'b0; rd_in = 5'd0;
        readdata_in = '0; alu_result_in = '0; rs1_addr = '0; rs2_addr = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        cnt = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        peek("rst_x5", 5'd5, 32'd0);
        peek("rst_x31", 5'd31, 32'd0);
        check("rst_count", wb_count, 32'd0);

        // reset clears stored data and drops a simultaneous write
        cyc(0, 1, 0, 5'd5, 32'd0, 32'h1234_5678, 5'd5, 5'd0);
        peek("x5_written", 5'd5, 32'h1234_5678);
        cyc(1, 1, 0, 5'd6, 32'd0, 32'hCAFE_F00D, 5'd5, 5'd6);
        peek("x5_after_rst", 5'd5, 32'd0);
        peek("x6_lost", 5'd6, 32'd0);
        check("count_after_rst", wb_count, 32'd0);

        // source select
        cyc(0, 1, 1, 5'd7, 32'hDEAD_BEEF, 32'h1, 5'd7, 5'd0);
        peek("x7_load", 5'd7, 32'hDEAD_BEEF);
        check("count_1", wb_count, 32'd1);
        cyc(0, 1, 0, 5'd7, 32'hDEAD_BEEF, 32'h1, 5'd7, 5'd7);
        peek("x7_alu", 5'd7, 32'h1);
        check("count_2", wb_count, 32'd2);

        // x0 protection
        cyc(0, 1, 0, 5'd0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        peek("x0", 5'd0, 32'd0);
        check("count_x0", wb_count, 32'd2);

        // same-cycle read of a register being written
        cyc(0, 1, 0, 5'd9, 32'd0, 32'hAAAA_AAAA, 5'd1, 5'd2);
        rs1_addr = 5'd9; rs2_addr = 5'd9; rd_in = 5'd9; memtoreg_in = 1'b0;
        alu_result_in = 32'h5555_5555; regwrite_in = 1'b1;
        #1;
        check("x9_same_cyc_p1", rs1_data, BYP ? 32'h5555_5555 : 32'hAAAA_AAAA);
        check("x9_same_cyc_p2", rs2_data, BYP ? 32'h5555_5555 : 32'hAAAA_AAAA);
        @(posedge clk);
        mem[9] = 32'h5555_5555; cnt = cnt + 32'd1;
        #1;
        peek("x9_next", 5'd9, 32'h5555_5555);

        // back-to-back writes with gaps
        cyc(0, 1, 0, 5'd3, 32'd0, 32'd1, 5'd3, 5'd9);
        cyc(0, 1, 0, 5'd3, 32'd0, 32'd2, 5'd3, 5'd3);
        cyc(0, 0, 0, 5'd4, 32'd0, 32'd7, 5'd3, 5'd4);
        cyc(0, 1, 1, 5'd4, 32'd9, 32'd0, 5'd4, 5'd3);
        peek("x3_b2b", 5'd3, 32'd2);
        check("count_b2b", wb_count, 32'd7);

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom),
                ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
                5'($urandom), ($urandom_range(0, 3) == 0) ? rd_in : 5'($urandom));
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the five-stage RISC-V pipeline. It consumes the MEM/WB pipeline register outputs, selects the writeback value, and commits it to a 32 x 32-bit integer register file. It serves the two combinational source-operand read ports used by decode. It also exports the current writeback triple to the forwarding unit and keeps a free-running count of committed register writes.

## Interface

Parameters:
- `XLEN`, 32, data width of each register.
- `NREG`, 32, number of registers; address width is log2(`NREG`) = 5.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `readdata_in`  in  32  load data from MEM/WB.
- `alu_result_in`  in  32  ALU result from MEM/WB.
- `rd_in`  in  5  destination register from MEM/WB.
- `memtoreg_in`  in  1  1 selects `readdata_in`, 0 selects `alu_result_in`.
- `regwrite_in`  in  1  writeback request from MEM/WB.
- `rs1_addr`  in  5  decode source 1 address.
- `rs2_addr`  in  5  decode source 2 address.
- `rs1_data`  out  32  combinational read data for `rs1_addr`.
- `rs2_data`  out  32  combinational read data for `rs2_addr`.
- `wb_data_out`  out  32  selected writeback value; combinational.
- `wb_rd_out`  out  5  equals `rd_in`.
- `wb_en_out`  out  1  `regwrite_in & (rd_in != 0)`; qualified write enable for the forwarding unit.
- `wb_count`  out  32  number of committed register writes since reset.

## Operation

- **Writeback select:** `wb_data_out = memtoreg_in ? readdata_in : alu_result_in`.
- **Commit:** on a rising edge with `reset` = 0 and `wb_en_out` = 1, `regs[rd_in] <= wb_data_out`.
- **x0:**
  - Writes to register 0 are discarded.
  - Reads of address 0 always return 0, regardless of stored contents or bypass.
- **Reads:** `rs1_data` and `rs2_data` are asynchronous reads of the register array, modified only by the bypass (see Configuration).
- **Dual reads:** the two read ports are independent. Identical addresses on both ports return identical data.
- **Commit counter:** `wb_count` increments by 1 on every committing edge.
  - Increments only when `wb_en_out` = 1, so writes to x0 do not count.
  - Wraps 0xFFFF_FFFF -> 0x0000_0000 with no flag.
- **Reset:**
  - On a rising edge with `reset` = 1, all 32 registers are cleared to 0 and `wb_count` is cleared to 0.
  - Reset has priority over a simultaneous write; that write is lost and not counted.
- **Reset values:**
  - `rs1_data`/`rs2_data` = 0 after the reset edge, for any address.
  - `wb_count` = 0.
  - `wb_data_out`, `wb_rd_out` and `wb_en_out` are combinational from inputs; they carry no reset value of their own and follow MEM/WB, which is itself reset to zeros.
- **Mid-operation reset:** reset asserted on any cycle takes effect at that edge. Writeback resumes on the first edge with `reset` = 0.

## Timing

- **Write latency:** one edge. Data presented in cycle N is stored at the end of cycle N.
- **Read-after-write, not same cycle:** a read in cycle N+1 of a register written at the end of cycle N returns the new value in all configurations.
- **Read-after-write, same cycle:** a read in cycle N of the register being written in cycle N depends on `WB_BYPASS_EN` (see Configuration).
- **Combinational paths:** `wb_*` outputs and read data have zero-cycle latency from their inputs. No handshake; the block accepts one writeback every cycle.

## Configuration

- Macro: `WB_BYPASS_EN`.
- **Defined:** write-through bypass. If `wb_en_out` = 1 and `rsX_addr == rd_in` (and `rd_in` != 0), `rsX_data = wb_data_out` in the same cycle. This removes the WB->ID hazard without the forwarding unit.
- **Undefined:**
  - Reads return the array contents, i.e. the old value during the write cycle.
  - The pipeline relies on the forwarding unit, fed from the `wb_*` outputs, or on a stall.
- Commit behaviour, x0 handling and `wb_count` are identical in both builds.

## Test plan

- **Reset:** write x5 = 0x1234_5678, then assert `reset` for one edge -> `rs1_addr` = 5 reads 0 and `wb_count` = 0. A write presented during the reset edge is not stored.
- **Source select:** `memtoreg_in` = 1, `readdata_in` = 0xDEAD_BEEF, `alu_result_in` = 0x1, `rd_in` = 7 -> next cycle x7 = 0xDEAD_BEEF. With `memtoreg_in` = 0 -> x7 = 0x1. `wb_count` advances 1 per write.
- **x0 protection:** `regwrite_in` = 1, `rd_in` = 0, data 0xFFFF_FFFF -> `wb_en_out` = 0, x0 reads 0 on both ports, `wb_count` unchanged.
- **Same-cycle read of a register being written:** x9 holds 0xAAAA_AAAA; write x9 = 0x5555_5555 while `rs1_addr` = `rs2_addr` = 9.
  - With `WB_BYPASS_EN`: both ports read 0x5555_5555 in the write cycle.
  - Without it: both read 0xAAAA_AAAA, then 0x5555_5555 the next cycle.
- **Back-to-back writes:** write x3 = 1 then x3 = 2 on consecutive cycles, with `regwrite_in` gaps elsewhere -> x3 = 2. `wb_count` equals the number of qualified writes.
- **Counter wrap:** force the count to 0xFFFF_FFFF via 2^32-1 writes (or use a bench with a preloaded counter), then one more write -> `wb_count` = 0.
